// File: rtl/insn_enc.sv
// Field-bundle to RV32 instruction encoder with a small output FIFO.
// Each word is encoded as it is accepted and queued together with a flag for an unencodable immediate or an unknown opcode.
module insn_enc #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic              err_o,
    output logic [15:0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);

    localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOADS    = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_STORES   = 7'b0100011;
    localparam logic [6:0] OP_BRANCHES = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;

    logic [DWIDTH-1:0] enc_insn;
    logic              enc_err;
    logic              fits12;
    logic              fits13;
    logic              fits21;
    logic              is_shift;

    logic [DWIDTH-1:0] mem_insn [DEPTH];
    logic              mem_err  [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       occ;
    logic              full;
    logic              push;
    logic              pop;

    // A sign-extended immediate fits its field when every bit above the field's sign bit matches it.
    assign fits12   = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13   = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits21   = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

    always_comb begin
        enc_insn = 32'h0000_0013;
        enc_err  = 1'b1;
        case (opcode_i)
            OP_R_TYPE: begin
                enc_insn = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = 1'b0;
            end
            OP_IMM: begin
                if (is_shift) begin
                    enc_insn = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc_err  = |imm_i[31:5];
                end else begin
                    enc_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc_err  = ~fits12;
                end
            end
            OP_LOADS, OP_JALR: begin
                enc_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = ~fits12;
            end
            OP_STORES: begin
                enc_insn = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = ~fits12;
            end
            OP_BRANCHES: begin
                enc_insn = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = imm_i[0] | ~fits13;
            end
            OP_JAL: begin
                enc_insn = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_err  = imm_i[0] | ~fits21;
            end
            OP_LUI, OP_AUIPC: begin
                enc_insn = {imm_i[31:12], rd_i, opcode_i};
                enc_err  = |imm_i[11:0];
            end
            default: begin
                enc_insn = 32'h0000_0013;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Ready depends on registered occupancy only, so a same-cycle pop never frees a full buffer.
    assign full        = (occ == FULL_OCC);
    assign in_ready_o  = ~full;
    assign out_valid_o = (occ != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign insn_o      = out_valid_o ? mem_insn[rptr] : '0;
    assign err_o       = out_valid_o ? mem_err[rptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wptr] <= enc_insn;
            mem_err[wptr]  <= enc_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr    <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
                count_o <= count_o + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_enc.sv
// Self-checking bench for insn_enc: expected words are queued on the scoreboard when a bundle is driven.
// Each word is then compared when the encoder delivers it.
module tb_insn_enc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] insn_o;
    logic        err_o;
    logic [15:0] count_o;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    int popped = 0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] ei;
        logic        ee;
    } case_t;

    logic [32:0] sb [$];

    insn_enc #(.DWIDTH(32), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .insn_o      (insn_o),
        .err_o       (err_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Present one bundle, record its expected result, and hold it until it is taken.
    task automatic drive(input case_t c, output bit ok);
        bit rdy;
        opcode_i   = c.op;
        rd_i       = c.rd;
        rs1_i      = c.rs1;
        rs2_i      = c.rs2;
        funct3_i   = c.f3;
        funct7_i   = c.f7;
        imm_i      = c.imm;
        in_valid_i = 1'b1;
        sb.push_back({c.ee, c.ei});
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            rdy = in_ready_o;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid_i = 1'b0;
    endtask

    // Wait for a head word, capture it, and let one edge pop it.
    task automatic take(output logic [31:0] insn, output logic err, output bit ok);
        out_ready_i = 1'b1;
        ok   = 1'b0;
        insn = '0;
        err  = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (out_valid_o) begin
                insn = insn_o;
                err  = err_o;
                ok   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_ready_i = 1'b0;
        if (ok) popped++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        popped = 0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (out_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid_o); else passes++;
        total++; if (insn_o !== 32'h0) $display("[TB] FAIL reset_insn: got %h expected 00000000", insn_o); else passes++;
        total++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_o); else passes++;
        total++; if (count_o !== 16'h0) $display("[TB] FAIL reset_count: got %h expected 0000", count_o); else passes++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (in_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", in_ready_o); else passes++;
    endtask

    task automatic test_encodings();
        case_t       cases [$];
        logic [32:0] exp;
        logic [31:0] ai;
        logic        ae;
        bit          ok;
        cases.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0});
        cases.push_back('{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0});
        cases.push_back('{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0163, 1'b1});
        cases.push_back('{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0});
        cases.push_back('{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0});
        cases.push_back('{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1});
        cases.push_back('{7'h7F, 5'd9, 5'd3, 5'd4, 3'd5, 7'd6, 32'h0000_1234, 32'h0000_0013, 1'b1});
        cases.push_back('{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0000, 32'h0020_81B3, 1'b0});
        cases.push_back('{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0});
        cases.push_back('{7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'h0000_0003, 32'h0030_9093, 1'b0});
        cases.push_back('{7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h0000_0020, 32'h4000_D093, 1'b1});
        cases.push_back('{7'h67, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_00E7, 1'b1});
        cases.push_back('{7'h03, 5'd1, 5'd0, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8000_2083, 1'b0});
        cases.push_back('{7'h17, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'hFFFF_F097, 1'b0});
        cases.push_back('{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_006F, 1'b1});
        cases.push_back('{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h8000_0063, 1'b1});
        foreach (cases[i]) begin
            drive(cases[i], ok);
            total++; if (!ok) $display("[TB] FAIL enc_accept[%0d]: got timeout expected accept", i); else passes++;
            total++; if (out_valid_o !== 1'b1) $display("[TB] FAIL enc_latency[%0d]: got %b expected 1", i, out_valid_o); else passes++;
            take(ai, ae, ok);
            exp = sb.pop_front();
            total++; if (!ok || ai !== exp[31:0]) $display("[TB] FAIL enc_insn[%0d]: got %h expected %h", i, ai, exp[31:0]); else passes++;
            total++; if (!ok || ae !== exp[32]) $display("[TB] FAIL enc_err[%0d]: got %b expected %b", i, ae, exp[32]); else passes++;
        end
        total++; if (count_o !== 16'(popped)) $display("[TB] FAIL enc_count: got %0d expected %0d", count_o, popped); else passes++;
    endtask

    task automatic test_backpressure();
        case_t       c [3];
        logic [32:0] exp;
        logic [31:0] ai;
        logic        ae;
        bit          ok0;
        bit          ok1;
        bit          ok2;
        do_reset();
        c[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0};
        c[1] = '{7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0};
        c[2] = '{7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0};
        drive(c[0], ok0);
        drive(c[1], ok1);
        total++; if (!(ok0 && ok1)) $display("[TB] FAIL bp_two_accepted: got %b%b expected 11", ok0, ok1); else passes++;
        total++; if (in_ready_o !== 1'b0) $display("[TB] FAIL bp_full_ready: got %b expected 0", in_ready_o); else passes++;
        fork
            drive(c[2], ok2);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                total++; if (in_ready_o !== 1'b0) $display("[TB] FAIL bp_held_ready: got %b expected 0", in_ready_o); else passes++;
                total++; if (insn_o !== 32'h0010_0093 || out_valid_o !== 1'b1) $display("[TB] FAIL bp_head_stable: got %h/%b expected 00100093/1", insn_o, out_valid_o); else passes++;
                for (int i = 0; i < 3; i++) begin
                    take(ai, ae, ok0);
                    exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
                    total++; if (!ok0 || ai !== exp[31:0] || ae !== exp[32]) $display("[TB] FAIL bp_order[%0d]: got %h/%b expected %h/%b", i, ai, ae, exp[31:0], exp[32]); else passes++;
                end
            end
        join
        total++; if (!ok2) $display("[TB] FAIL bp_third_accept: got timeout expected accept"); else passes++;
        total++; if (count_o !== 16'd3) $display("[TB] FAIL bp_count: got %0d expected 3", count_o); else passes++;
        total++; if (out_valid_o !== 1'b0) $display("[TB] FAIL bp_drained: got %b expected 0", out_valid_o); else passes++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        case_t       c;
        logic [11:0] r;
        logic [32:0] exp;
        logic [31:0] ai;
        logic        ae;
        bit          okd;
        bit          okt;
        int          start;
        int          base;
        base  = popped;
        start = cyc;
        fork
            for (int i = 0; i < N; i++) begin
                r    = 12'($urandom);
                c.op = 7'h13;
                c.rd = 5'($urandom_range(1, 31));
                c.rs1 = 5'($urandom);
                c.rs2 = 5'd0;
                c.f3 = 3'd0;
                c.f7 = 7'd0;
                c.imm = {{20{r[11]}}, r};
                c.ei = {r, c.rs1, 3'b000, c.rd, 7'b0010011};
                c.ee = 1'b0;
                drive(c, okd);
                total++; if (!okd) $display("[TB] FAIL b2b_accept[%0d]: got timeout expected accept", i); else passes++;
            end
            for (int i = 0; i < N; i++) begin
                take(ai, ae, okt);
                exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
                total++; if (!okt || ai !== exp[31:0] || ae !== exp[32]) $display("[TB] FAIL b2b_data[%0d]: got %h/%b expected %h/%b", i, ai, ae, exp[31:0], exp[32]); else passes++;
            end
        join
        total++; if (cyc - start > N + 2) $display("[TB] FAIL b2b_throughput: got %0d cycles expected at most %0d", cyc - start, N + 2); else passes++;
        total++; if (count_o !== 16'(base + N)) $display("[TB] FAIL b2b_count: got %0d expected %0d", count_o, base + N); else passes++;
    endtask

    task automatic test_reset_midop();
        case_t c;
        bit    ok0;
        bit    ok1;
        c = '{7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E3B7, 1'b0};
        drive(c, ok0);
        drive(c, ok1);
        total++; if (!(ok0 && ok1) || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) $display("[TB] FAIL mid_prefill: got %b%b valid %b ready %b expected 11 valid 1 ready 0", ok0, ok1, out_valid_o, in_ready_o); else passes++;
        #3;
        reset = 1'b1;
        #1;
        total++; if (out_valid_o !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", out_valid_o); else passes++;
        total++; if (count_o !== 16'h0) $display("[TB] FAIL mid_count: got %0d expected 0", count_o); else passes++;
        total++; if (insn_o !== 32'h0 || err_o !== 1'b0) $display("[TB] FAIL mid_outputs: got %h/%b expected 00000000/0", insn_o, err_o); else passes++;
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        total++; if (in_ready_o !== 1'b1) $display("[TB] FAIL mid_ready: got %b expected 1", in_ready_o); else passes++;
        out_ready_i = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_ready_i = 1'b0;
        total++; if (out_valid_o !== 1'b0 || count_o !== 16'h0) $display("[TB] FAIL mid_no_residue: got valid %b count %0d expected 0/0", out_valid_o, count_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/insn_enc.md
INSN_ENC -- requirements
Module: insn_enc

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, giving the instruction word width; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of output buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid_i, input, 1 bit: the field bundle is valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the encoder accepts a bundle this cycle.
REQ-007 SHALL have ports opcode_i (7 bits), rd_i (5), rs1_i (5), rs2_i (5), funct3_i (3) and funct7_i (7), all inputs: the instruction fields.
REQ-008 SHALL have port imm_i, input, 32 bits: the full sign-extended immediate or byte offset, in the same form the immediate generator produces.
REQ-009 SHALL have port out_valid_o, output, 1 bit: the buffer head is valid.
REQ-010 SHALL have port out_ready_i, input, 1 bit: the consumer takes the head this cycle.
REQ-011 SHALL have port insn_o, output, DWIDTH bits: the encoded instruction at the buffer head.
REQ-012 SHALL have port err_o, output, 1 bit: the head instruction had an unencodable immediate or an unknown opcode.
REQ-013 SHALL have port count_o, output, 16 bits: the number of instructions delivered.

Function
REQ-014 SHALL accept a bundle on a rising edge where in_valid_i=1 and in_ready_o=1.
REQ-015 SHALL encode an accepted bundle combinationally and push it into a DEPTH-entry FIFO together with its error bit.
REQ-016 SHALL drive in_ready_o = !full, computed from registered state only, with no path from out_ready_i; a full buffer rejects input even when a pop occurs in the same cycle.
REQ-017 SHALL have latency 1: a bundle accepted at edge N appears with out_valid_o=1 after edge N when the buffer was empty.
REQ-018 SHALL pop on a rising edge where out_valid_o=1 and out_ready_i=1; insn_o and err_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-019 SHALL handle a simultaneous push and pop on a non-full, non-empty buffer with occupancy unchanged and order preserved; on an empty buffer, a push with out_ready_i=1 SHALL NOT bypass the buffer.
REQ-020 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-021 SHALL encode opcode R_TYPE as {funct7, rs2, rs1, funct3, rd, op} with err=0.
REQ-022 SHALL encode opcodes IMM, LOADS and JALR as {imm[11:0], rs1, funct3, rd, op}, with err=1 unless imm[31:11] are all equal.
REQ-023 SHALL encode IMM with funct3 001 or 101 (shifts) as {funct7, imm[4:0], rs1, funct3, rd, op}, with err=1 unless imm[31:5]=0.
REQ-024 SHALL encode STORES as {imm[11:5], rs2, rs1, funct3, imm[4:0], op}, with err=1 unless imm[31:11] are all equal.
REQ-025 SHALL encode BRANCHES as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}, with err=1 if imm[0]=1 or imm[31:12] are not all equal.
REQ-026 SHALL encode JAL as {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}, with err=1 if imm[0]=1 or imm[31:20] are not all equal.
REQ-027 SHALL encode LUI and AUIPC as {imm[31:12], rd, op}, with err=1 if imm[11:0] is nonzero.
REQ-028 SHALL encode any other opcode as insn=32'h0000_0013 (NOP) with err=1.
REQ-029 SHALL, on err=1 for a known opcode, still emit the truncated field packing.
REQ-030 SHALL increment count_o by 1 on each pop, wrapping from 16'hFFFF to 0.

Reset
REQ-031 SHALL, while reset=1, immediately (asynchronously) empty the FIFO and drive out_valid_o=0, insn_o=0, err_o=0 and count_o=0.
REQ-032 SHALL drive in_ready_o=1 from the first edge after reset deasserts.
REQ-033 SHALL discard buffered entries on reset mid-operation, with no partial output afterwards.

Verification
REQ-034 SHALL pass: ADDI opcode 0010011, rd=1, rs1=0, f3=0, imm=32'hFFFF_FFFF -> insn_o=32'hFFF0_0093, err_o=0, out_valid_o=1 one cycle after accept.
REQ-035 SHALL pass: BRANCHES f3=0, rs1=rs2=0, imm=-4 -> 32'hFE00_0EE3, err_o=0; the same bundle with imm=3 -> err_o=1.
REQ-036 SHALL pass: JAL rd=1, imm=32'h800 -> 32'h0010_00EF; LUI rd=5, imm=32'h1234_5000 -> 32'h1234_52B7; LUI imm=32'h1234_5001 -> err_o=1.
REQ-037 SHALL pass: DEPTH=2, out_ready_i=0, three back-to-back bundles -> two accepted, in_ready_o=0, third held; then out_ready_i=1 -> three outputs in order and count_o=3.
REQ-038 SHALL pass: opcode 7'h7F -> 32'h0000_0013, err_o=1.
REQ-039 SHALL pass: two entries buffered, reset pulsed mid-cycle -> out_valid_o=0 and count_o=0 before the next edge, and in_ready_o=1 after release.
